// File: rtl/rfarb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Contents: XLEN_DEF and REG_ADDR_W, rfarb_entry_t (default FIFO entry: rd + data),
// and grant_t (which source owns the write port this cycle).
package rfarb_pkg;

  localparam int unsigned XLEN_DEF   = 64;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
  } rfarb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_LU
  } grant_t;

endpackage

// File: rtl/rfarb_if.sv
// Bus bundle of the register-file write arbiter.
// master: the pipeline side (WB request, LU result stream, long-latency issue);
//         observes lu_ready, rf_we/rf_rw/rf_din, pend_mask, hold_req, arb_err.
// slave : the arbiter itself.
interface rfarb_if import rfarb_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEF
) ();

  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;

  logic                  lu_valid;
  logic                  lu_ready;
  logic [REG_ADDR_W-1:0] lu_rd;
  logic [XLEN-1:0]       lu_data;

  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_rw;
  logic [XLEN-1:0]       rf_din;

  logic [31:0]           pend_mask;
  logic                  hold_req;
  logic                  arb_err;

  modport master (
    output wb_we, wb_rd, wb_data, lu_valid, lu_rd, lu_data, issue_valid, issue_rd,
    input  lu_ready, rf_we, rf_rw, rf_din, pend_mask, hold_req, arb_err
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, lu_valid, lu_rd, lu_data, issue_valid, issue_rd,
    output lu_ready, rf_we, rf_rw, rf_din, pend_mask, hold_req, arb_err
  );

endinterface

// File: rtl/rfarb_fifo.sv
// DEPTH-entry synchronous FIFO holding long-latency results.
// Ports: clock, reset (async, active-low), push/push_data, pop,
//        full, empty, head (oldest entry, valid only when !empty).
// A push while full is taken only together with a pop.
module rfarb_fifo import rfarb_pkg::*; #(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = rfarb_entry_t
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between WB (priority) and a
// long-latency unit whose results queue in rfarb_fifo and drain in WB-idle cycles.
// Ports: clock, reset (async, active-low), bus (rfarb_if.slave: WB request,
//        LU stream + lu_ready, issue, rf_we/rf_rw/rf_din, pend_mask, hold_req, arb_err).
// Optional: RFARB_STATS_EN adds conflict_cnt[31:0], counting cycles where a
//           WB write coincides with a non-empty FIFO.
module rf_write_arbiter import rfarb_pkg::*; #(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  rfarb_if.slave      bus
`ifdef RFARB_STATS_EN
  ,
  output logic [31:0] conflict_cnt
`endif
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } entry_t;

  localparam int unsigned AW = $clog2(STARVE_MAX + 1);

  entry_t        push_data;
  entry_t        head;
  logic          full;
  logic          empty;
  logic          pop;
  logic          wb_req;
  grant_t        grant;
  logic [AW-1:0] age;
  logic [AW-1:0] age_next;
  logic [31:0]   pend_next;

  assign push_data    = '{rd: bus.lu_rd, data: bus.lu_data};
  assign bus.lu_ready = !full;
  assign wb_req       = bus.wb_we && (bus.wb_rd != '0);

  rfarb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (bus.lu_valid && !full),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  // Grant is gated by reset so nothing reaches the register file while reset is low.
  always_comb begin
    grant = GNT_NONE;
    if (!reset)                     grant = GNT_NONE;
    else if (bus.hold_req && !empty) grant = GNT_LU;
    else if (wb_req)                grant = GNT_WB;
    else if (!empty)                grant = GNT_LU;
  end

  assign pop = (grant == GNT_LU);

  always_comb begin
    bus.rf_we  = 1'b0;
    bus.rf_rw  = '0;
    bus.rf_din = '0;
    case (grant)
      GNT_WB: begin
        bus.rf_we  = 1'b1;
        bus.rf_rw  = bus.wb_rd;
        bus.rf_din = bus.wb_data;
      end
      GNT_LU: begin
        // An x0-targeted result is discarded: popped without a write.
        bus.rf_we  = (head.rd != '0);
        bus.rf_rw  = head.rd;
        bus.rf_din = head.data;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (empty || pop)                   age_next = '0;
    else if (age != AW'(STARVE_MAX))    age_next = age + AW'(1);
    else                                age_next = age;
  end

  // Set is applied after clear so a same-register issue in the pop cycle wins.
  always_comb begin
    pend_next = bus.pend_mask;
    if (pop) pend_next[head.rd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != '0)) pend_next[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      age           <= '0;
      bus.hold_req  <= 1'b0;
      bus.arb_err   <= 1'b0;
      bus.pend_mask <= '0;
    end else begin
      age           <= age_next;
      bus.hold_req  <= (age_next == AW'(STARVE_MAX));
      bus.arb_err   <= bus.arb_err | (bus.hold_req && bus.wb_we);
      bus.pend_mask <= pend_next;
    end
  end

`ifdef RFARB_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                conflict_cnt <= '0;
    else if (wb_req && !empty) conflict_cnt <= conflict_cnt + 32'd1;
  end
`endif

endmodule
